// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Optional write-through forwarding: REGFILE_SB_BYPASS_EN.
package regfile_sb_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NRD   = 2;
  localparam int ZERO_REG  = 0;

  function automatic logic signed [1:0] popcount_delta(
    input logic set_hit,
    input logic clr_hit
  );
    logic signed [1:0] d;
    d = 2'sd0;
    if (set_hit & ~clr_hit)
      d = 2'sd1;
    else if (clr_hit & ~set_hit)
      d = -2'sd1;
    return d;
  endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One read port: zero-register mux plus forwarding mux.
// i_hit is tied low unless REGFILE_SB_BYPASS_EN is defined.
module regfile_sb_rdport #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_mem,
  input  logic          i_zero,
  input  logic          i_busy,
  input  logic          i_hit,
  input  logic [DW-1:0] i_wr_data,
  output logic [DW-1:0] o_data,
  output logic          o_busy
);

  always_comb begin
    o_data = i_mem;
    unique case (1'b1)
      i_zero:  o_data = '0;
      i_hit:   o_data = i_wr_data;
      default: o_data = i_mem;
    endcase
  end

  assign o_busy = i_busy & ~i_hit & ~i_zero;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard.
// Define REGFILE_SB_BYPASS_EN for same-cycle writeback forwarding.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int NRD   = DEF_NRD,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              stall,
  output logic [AW:0]       busy_cnt
);

  logic [DW-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [AW:0]       r_cnt;

  logic              w_wr_ok;
  logic              w_iss_ok;
  logic              w_set_hit;
  logic              w_clr_hit;
  logic signed [1:0] w_delta;
  logic [NRD-1:0]    w_hit;

  assign w_wr_ok  = wr_en  & (wr_addr  != AW'(ZERO_REG));
  assign w_iss_ok = iss_en & (iss_addr != AW'(ZERO_REG));

  // A new issue supersedes a same-cycle writeback to that register.
  assign w_set_hit = w_iss_ok & ~r_busy[iss_addr];
  assign w_clr_hit = w_wr_ok & r_busy[wr_addr]
                   & ~(w_iss_ok & (iss_addr == wr_addr));
  assign w_delta   = popcount_delta(w_set_hit, w_clr_hit);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[wr_addr]  <= wr_data;
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_iss_ok)
        r_busy[iss_addr] <= 1'b1;
      r_cnt <= r_cnt + {{(AW-1){w_delta[1]}}, w_delta};
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = rd_addr[p*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
    assign w_hit[p] = w_wr_ok & (wr_addr == w_addr);
`else
    assign w_hit[p] = 1'b0;
`endif
    regfile_sb_rdport #(.DW(DW)) u_rd (
      .i_mem     (r_mem[w_addr]),
      .i_zero    (w_addr == AW'(ZERO_REG)),
      .i_busy    (r_busy[w_addr]),
      .i_hit     (w_hit[p]),
      .i_wr_data (wr_data),
      .o_data    (rd_data[p*DW +: DW]),
      .o_busy    (rd_busy[p])
    );
  end

  assign stall    = |(rd_en & rd_busy);
  assign busy_cnt = r_cnt;

endmodule
